// File: rtl/fft64_pkg.sv
// Shared constants, controller state encoding and index helpers for the
// 64-point radix-2 SDF FFT sequencing logic.
package fft64_pkg;
  localparam int FFT_N     = 64;
  localparam int FFT_LOG2N = 6;
  localparam int FFT_LAT   = 63;

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_PAD, ST_FLUSH} state_e;

  function automatic logic [FFT_LOG2N-1:0] bitrev6(input logic [FFT_LOG2N-1:0] v);
    logic [FFT_LOG2N-1:0] r;
    for (int i = 0; i < FFT_LOG2N; i++) r[i] = v[FFT_LOG2N-1-i];
    return r;
  endfunction

  // Delay-line length of stage s: 32,16,8,4,2,1.
  function automatic int stage_delay(input int s);
    return (FFT_N / 2) >> s;
  endfunction
endpackage

// File: rtl/fft64_stage_seq.sv
// Per-stage sequencer: maps the shared frame counter to this stage's
// butterfly select and twiddle ROM index.
module fft64_stage_seq
  import fft64_pkg::*;
#(
  parameter int STAGE = 0
) (
  input  logic [FFT_LOG2N-1:0] cnt,
  output logic                 bf_sel,
  output logic [4:0]           tw_addr
);
  localparam int                   D     = stage_delay(STAGE);
  localparam logic [FFT_LOG2N-1:0] OFF   = FFT_LOG2N'(FFT_N - 2*D);
  localparam logic [FFT_LOG2N-1:0] MASK  = FFT_LOG2N'(D - 1);
  localparam logic [FFT_LOG2N-1:0] BFBIT = FFT_LOG2N'(1 << (5 - STAGE));

  logic [FFT_LOG2N-1:0] c, m;

  // Local count is offset by the delay of all earlier stages, so the
  // window of each stage lines up with data leaving its delay line.
  always_comb begin
    c       = cnt - OFF;
    m       = c & MASK;
    bf_sel  = |(c & BFBIT);
    tw_addr = 5'(m << STAGE);
  end
endmodule

// File: rtl/fft64_sdf_ctrl.sv
// Sequencing controller for the 64-point SDF FFT pipeline. Optional output
// frame counter enabled by defining FFT64_SDF_CTRL_FRAME_CNT_EN.
module fft64_sdf_ctrl
  import fft64_pkg::*;
#(
  parameter int LAT = FFT_LAT,
  parameter int FCW = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  output logic           zero_in,
  output logic           adv,
  output logic [5:0]     bf_sel,
  output logic [29:0]    tw_addr,
  output logic           out_valid,
  output logic [5:0]     out_idx,
  output logic           out_last,
  output logic           busy,
  output logic [FCW-1:0] frame_cnt
);
  localparam logic [FFT_LOG2N-1:0] LAT_Q      = FFT_LOG2N'(LAT);
  localparam logic [FFT_LOG2N-1:0] LAT_M1     = FFT_LOG2N'(LAT - 1);
  localparam logic [FFT_LOG2N-1:0] FLUSH_LAST = FFT_LOG2N'(LAT - 2);
  localparam logic [FFT_LOG2N-1:0] CNT_MAX    = FFT_LOG2N'(FFT_N - 1);

  state_e               state_q, state_d;
  logic [FFT_LOG2N-1:0] cnt_q, cnt_d, fill_q, fill_d;
  logic [FFT_LOG2N-1:0] flush_cnt_q, flush_cnt_d, out_cnt_q, out_cnt_d;
  logic                 out_valid_q, out_valid_d;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    fill_d      = fill_q;
    flush_cnt_d = flush_cnt_q;
    adv         = 1'b0;
    zero_in     = 1'b0;
    in_ready    = 1'b1;
    case (state_q)
      ST_IDLE: begin
        adv = in_valid;
        if (in_valid) state_d = ST_RUN;
      end
      ST_RUN: begin
        adv = in_valid;
        if (!in_valid) state_d = (cnt_q != '0) ? ST_PAD : ST_FLUSH;
      end
      ST_PAD: begin
        adv      = 1'b1;
        zero_in  = 1'b1;
        in_ready = 1'b0;
        if (cnt_q == CNT_MAX) state_d = ST_FLUSH;
      end
      ST_FLUSH: begin
        adv         = 1'b1;
        zero_in     = 1'b1;
        in_ready    = 1'b0;
        flush_cnt_d = flush_cnt_q + 1'b1;
        if (flush_cnt_q == FLUSH_LAST) begin
          state_d     = ST_IDLE;
          flush_cnt_d = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (adv) begin
      cnt_d = cnt_q + 1'b1;
      if (fill_q != LAT_Q) fill_d = fill_q + 1'b1;
    end
    // Every frame must start at cnt 0 with an empty fill history.
    if (state_d == ST_IDLE) begin
      cnt_d  = '0;
      fill_d = '0;
    end
    out_valid_d = adv && ((fill_q >= LAT_M1) || (state_q == ST_FLUSH));
    out_cnt_d   = out_cnt_q + {5'd0, out_valid_q};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      fill_q      <= '0;
      flush_cnt_q <= '0;
      out_cnt_q   <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      fill_q      <= fill_d;
      flush_cnt_q <= flush_cnt_d;
      out_cnt_q   <= out_cnt_d;
      out_valid_q <= out_valid_d;
    end
  end

  for (genvar s = 0; s < FFT_LOG2N; s++) begin : g_stage
    fft64_stage_seq #(.STAGE(s)) u_seq (
      .cnt     (cnt_q),
      .bf_sel  (bf_sel[s]),
      .tw_addr (tw_addr[5*s +: 5])
    );
  end

  assign busy      = (state_q != ST_IDLE);
  assign out_valid = out_valid_q;
  assign out_idx   = bitrev6(out_cnt_q);
  assign out_last  = out_valid_q && (out_cnt_q == CNT_MAX);

`ifdef FFT64_SDF_CTRL_FRAME_CNT_EN
  logic [FCW-1:0] frame_cnt_q, frame_cnt_d;

  always_comb frame_cnt_d = frame_cnt_q + FCW'(out_last);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) frame_cnt_q <= '0;
    else        frame_cnt_q <= frame_cnt_d;
  end

  assign frame_cnt = frame_cnt_q;
`else
  assign frame_cnt = '0;
`endif
endmodule
